// File: rtl/psram_arb_pkg.sv
// Shared definitions for the PSRAM port arbiter: FSM encoding, error word,
// watchdog default and small width helpers.
package psram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic [31:0]  ERR_WORD      = 32'hDEADBEEF;
  localparam int unsigned  TO_CYCLES_DEF = 1023;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Counter width able to hold the value lim; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned lim);
    return (lim < 2) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first pending requester at or after i_ptr, scanning
// circularly. Purely combinational.
module rr_pick
  import psram_arb_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]               i_pend,
  input  logic [idx_width(N)-1:0]    i_ptr,
  output logic [N-1:0]               o_grant_oh_c,
  output logic [idx_width(N)-1:0]    o_idx_c,
  output logic                       o_any_c
);

  localparam int unsigned PW = idx_width(N);

  // (p + k) mod N, valid for p < N and k < N
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  logic          w_found;
  logic [PW-1:0] w_cand;

  always_comb begin
    w_found = 1'b0;
    w_cand  = '0;
    o_idx_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = wrap_idx(i_ptr, k);
      if (!w_found && i_pend[w_cand]) begin
        w_found = 1'b1;
        o_idx_c = w_cand;
      end
    end
  end

  assign o_any_c      = w_found;
  assign o_grant_oh_c = w_found ? (N'(1) << o_idx_c) : '0;

endmodule

// File: rtl/psram_port_arbiter.sv
// Round-robin arbiter sharing one word-wide PSRAM controller between N_PORTS
// requesters; one outstanding transaction, watchdog on the completion wait.
module psram_port_arbiter
  import psram_arb_pkg::*;
#(
  parameter int unsigned N_PORTS   = 3,
  parameter int unsigned AW        = 22,
  parameter int unsigned DW        = 32,
  parameter int unsigned TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic                  clk_mem,
  input  logic                  rst,
  input  logic [N_PORTS-1:0]    req_rd,
  input  logic [N_PORTS-1:0]    req_we,
  input  logic [N_PORTS*AW-1:0] req_a,
  input  logic [N_PORTS*DW-1:0] req_d,
  output logic [N_PORTS-1:0]    rsp_done,
  output logic                  rsp_err,
  output logic [DW-1:0]         rsp_rdata,
  output logic [AW-1:0]         mem_a,
  output logic [DW-1:0]         mem_d,
  output logic                  mem_rd,
  output logic                  mem_we,
  input  logic [DW-1:0]         mem_spo,
  input  logic                  mem_ready,
  output logic                  busy
);

  localparam int unsigned PW = idx_width(N_PORTS);
  localparam int unsigned WW = cnt_width(TO_CYCLES);
  localparam logic [WW-1:0] WD_LIMIT  = WW'(TO_CYCLES);
  localparam logic [PW-1:0] LAST_PORT = PW'(N_PORTS - 1);

  arb_state_t r_state, w_state_nxt;

  logic [PW-1:0]      r_ptr, w_ptr_nxt;
  logic [PW-1:0]      r_gidx, w_gidx_nxt;
  logic               r_op, w_op_nxt;          // 1 = write
  logic               r_armed, w_armed_nxt;    // completion may be sampled
  logic [WW-1:0]      r_wd, w_wd_nxt, w_wd_inc;

  logic [N_PORTS-1:0] w_pend, w_pick_oh, w_gnt_oh, w_done_nxt;
  logic [PW-1:0]      w_pick_idx;
  logic               w_pick_any;
  logic [AW-1:0]      w_a_nxt;
  logic [DW-1:0]      w_d_nxt, w_rdata_nxt;
  logic               w_rd_nxt, w_we_nxt, w_err_nxt;

  assign w_pend   = req_rd | req_we;
  assign w_gnt_oh = N_PORTS'(1) << r_gidx;
  assign w_wd_inc = r_wd + WW'(1);

  rr_pick #(.N(N_PORTS)) u_rr_pick (
    .i_pend       (w_pend),
    .i_ptr        (r_ptr),
    .o_grant_oh_c (w_pick_oh),
    .o_idx_c      (w_pick_idx),
    .o_any_c      (w_pick_any)
  );

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gidx_nxt  = r_gidx;
    w_op_nxt    = r_op;
    w_armed_nxt = r_armed;
    w_wd_nxt    = r_wd;
    w_a_nxt     = mem_a;
    w_d_nxt     = mem_d;
    w_rd_nxt    = 1'b0;
    w_we_nxt    = 1'b0;
    w_done_nxt  = '0;
    w_err_nxt   = 1'b0;
    w_rdata_nxt = rsp_rdata;

    unique case (r_state)
      ST_IDLE: begin
        // mem_ready low covers both PSRAM init and a controller still finishing
        if (w_pick_any && mem_ready) begin
          w_gidx_nxt  = w_pick_idx;
          w_op_nxt    = |(req_we & w_pick_oh);
          w_a_nxt     = req_a[32'(w_pick_idx) * AW +: AW];
          w_d_nxt     = req_d[32'(w_pick_idx) * DW +: DW];
          w_we_nxt    = w_op_nxt;
          w_rd_nxt    = !w_op_nxt;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_wd_nxt    = '0;
        w_armed_nxt = 1'b0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_armed && mem_ready) begin
          if (!r_op) w_rdata_nxt = mem_spo;
          w_done_nxt  = w_gnt_oh;
          w_state_nxt = ST_RESP;
        end else begin
          // The first WAIT cycle never samples ready but still counts toward the watchdog
          w_armed_nxt = 1'b1;
          w_wd_nxt    = w_wd_inc;
          if ((TO_CYCLES != 0) && (w_wd_inc == WD_LIMIT)) begin
            w_done_nxt  = w_gnt_oh;
            w_err_nxt   = 1'b1;
            w_rdata_nxt = DW'(ERR_WORD);
            w_state_nxt = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        w_ptr_nxt   = (r_gidx == LAST_PORT) ? '0 : r_gidx + PW'(1);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_mem) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath and output registers
  always_ff @(posedge clk_mem) begin
    if (rst) begin
      r_ptr     <= '0;
      r_gidx    <= '0;
      r_op      <= 1'b0;
      r_armed   <= 1'b0;
      r_wd      <= '0;
      mem_a     <= '0;
      mem_d     <= '0;
      mem_rd    <= 1'b0;
      mem_we    <= 1'b0;
      rsp_done  <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      r_ptr     <= w_ptr_nxt;
      r_gidx    <= w_gidx_nxt;
      r_op      <= w_op_nxt;
      r_armed   <= w_armed_nxt;
      r_wd      <= w_wd_nxt;
      mem_a     <= w_a_nxt;
      mem_d     <= w_d_nxt;
      mem_rd    <= w_rd_nxt;
      mem_we    <= w_we_nxt;
      rsp_done  <= w_done_nxt;
      rsp_err   <= w_err_nxt;
      rsp_rdata <= w_rdata_nxt;
      busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  a_single_op: assert property (@(posedge clk_mem) disable iff (rst) !(mem_rd && mem_we));
  a_done_oh:   assert property (@(posedge clk_mem) disable iff (rst) $onehot0(rsp_done));
  a_err_done:  assert property (@(posedge clk_mem) disable iff (rst) rsp_err |-> (|rsp_done));

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Directed bench for psram_port_arbiter: a vector table of single transactions
// plus hand-written sequences for init stall, rr order, watchdog and reset.
module tb_psram_port_arbiter;
  import psram_arb_pkg::*;

  localparam int unsigned NP = 3;
  localparam int unsigned AW = 22;
  localparam int unsigned DW = 32;

  logic clk_mem = 1'b0;
  always #5 clk_mem = ~clk_mem;

  logic             rst;
  logic [NP-1:0]    req_rd, req_we;
  logic [AW-1:0]    a_port [NP];
  logic [DW-1:0]    d_port [NP];
  logic [NP*AW-1:0] req_a;
  logic [NP*DW-1:0] req_d;

  for (genvar g = 0; g < NP; g++) begin : g_pack
    assign req_a[g*AW +: AW] = a_port[g];
    assign req_d[g*DW +: DW] = d_port[g];
  end

  // Index 0: default watchdog; index 1: TO_CYCLES=16
  logic [NP-1:0] rsp_done  [2];
  logic          rsp_err   [2];
  logic [DW-1:0] rsp_rdata [2];
  logic [AW-1:0] mem_a     [2];
  logic [DW-1:0] mem_d     [2];
  logic          mem_rd    [2];
  logic          mem_we    [2];
  logic [DW-1:0] mem_spo   [2];
  logic          mem_ready [2];
  logic          busy      [2];

  psram_port_arbiter #(.N_PORTS(NP), .AW(AW), .DW(DW)) u_dut (
    .clk_mem(clk_mem), .rst(rst), .req_rd(req_rd), .req_we(req_we), .req_a(req_a), .req_d(req_d),
    .rsp_done(rsp_done[0]), .rsp_err(rsp_err[0]), .rsp_rdata(rsp_rdata[0]),
    .mem_a(mem_a[0]), .mem_d(mem_d[0]), .mem_rd(mem_rd[0]), .mem_we(mem_we[0]),
    .mem_spo(mem_spo[0]), .mem_ready(mem_ready[0]), .busy(busy[0]));

  psram_port_arbiter #(.N_PORTS(NP), .AW(AW), .DW(DW), .TO_CYCLES(16)) u_dut_to (
    .clk_mem(clk_mem), .rst(rst), .req_rd(req_rd), .req_we(req_we), .req_a(req_a), .req_d(req_d),
    .rsp_done(rsp_done[1]), .rsp_err(rsp_err[1]), .rsp_rdata(rsp_rdata[1]),
    .mem_a(mem_a[1]), .mem_d(mem_d[1]), .mem_rd(mem_rd[1]), .mem_we(mem_we[1]),
    .mem_spo(mem_spo[1]), .mem_ready(mem_ready[1]), .busy(busy[1]));

  // ---------------- controller model ----------------
  bit ready_en;
  bit hang1;
  int svc_cfg;

  logic          ready_q    [2];
  int            svc_left   [2];
  logic [AW-1:0] cap_a      [2];
  logic [DW-1:0] cap_d      [2];
  logic          prev_pulse [2];
  int            rd_cnt     [2];
  int            we_cnt     [2];
  int            long_cnt   [2];

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_rdy
    assign mem_ready[g] = ready_q[g] && !mem_rd[g] && !mem_we[g];
  end

  always @(posedge clk_mem) begin
    for (int m = 0; m < 2; m++) begin
      prev_pulse[m] <= mem_rd[m] | mem_we[m];
      if (rst) begin
        ready_q[m]  <= 1'b0;
        svc_left[m] <= 0;
        mem_spo[m]  <= '0;
      end else if (mem_rd[m] || mem_we[m]) begin
        ready_q[m]  <= 1'b0;
        svc_left[m] <= svc_cfg;
        cap_a[m]    <= mem_a[m];
        cap_d[m]    <= mem_d[m];
        if (mem_rd[m]) rd_cnt[m] <= rd_cnt[m] + 1;
        if (mem_we[m]) we_cnt[m] <= we_cnt[m] + 1;
        if (prev_pulse[m] === 1'b1) long_cnt[m] <= long_cnt[m] + 1;
      end else if (svc_left[m] > 1) begin
        svc_left[m] <= svc_left[m] - 1;
      end else begin
        svc_left[m] <= 0;
        mem_spo[m]  <= model_rd(cap_a[m]);
        if (ready_en && !(m == 1 && hang1)) ready_q[m] <= 1'b1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_mem);
  endtask

  task automatic do_reset();
    @(negedge clk_mem);
    rst = 1'b1; req_rd = '0; req_we = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_done(input int m, input int budget, output int cycles, output bit ok);
    cycles = 0; ok = 1'b0;
    while (cycles < budget && !ok) begin
      @(negedge clk_mem);
      cycles++;
      if (rsp_done[m] != '0) ok = 1'b1;
    end
  endtask

  task automatic wait_pulse(input int m, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk_mem);
      if (mem_rd[m] || mem_we[m]) ok = 1'b1;
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_done"},   64'(rsp_done[0]),  64'd0);
    chk({tag, "_err"},    64'(rsp_err[0]),   64'd0);
    chk({tag, "_rdata"},  64'(rsp_rdata[0]), 64'd0);
    chk({tag, "_mem_a"},  64'(mem_a[0]),     64'd0);
    chk({tag, "_mem_d"},  64'(mem_d[0]),     64'd0);
    chk({tag, "_rd_we"},  64'({mem_rd[0], mem_we[0]}), 64'd0);
    chk({tag, "_busy"},   64'(busy[0]),      64'd0);
  endtask

  typedef struct {
    logic [NP-1:0] rd;
    logic [NP-1:0] we;
    int            svc;
    int            port;
    logic          exp_we;
    logic [NP-1:0] exp_done;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #300000;
    $display("FAIL global_timeout: got no summary by 300us, expected bench to finish");
    $fatal(1);
  end

  initial begin
    int  cyc, rd0, we0, l0;
    bit  ok;
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] prev_rdata;

    vecs[0] = '{rd: 3'b000, we: 3'b001, svc: 20, port: 0, exp_we: 1'b1, exp_done: 3'b001};
    vecs[1] = '{rd: 3'b010, we: 3'b000, svc: 3,  port: 1, exp_we: 1'b0, exp_done: 3'b010};
    vecs[2] = '{rd: 3'b100, we: 3'b100, svc: 2,  port: 2, exp_we: 1'b1, exp_done: 3'b100};
    vecs[3] = '{rd: 3'b011, we: 3'b000, svc: 1,  port: 0, exp_we: 1'b0, exp_done: 3'b001};
    vecs[4] = '{rd: 3'b101, we: 3'b000, svc: 4,  port: 2, exp_we: 1'b0, exp_done: 3'b100};
    vecs[5] = '{rd: 3'b000, we: 3'b110, svc: 2,  port: 1, exp_we: 1'b1, exp_done: 3'b010};
    vecs[6] = '{rd: 3'b001, we: 3'b000, svc: 1,  port: 0, exp_we: 1'b0, exp_done: 3'b001};
    vecs[7] = '{rd: 3'b100, we: 3'b000, svc: 5,  port: 2, exp_we: 1'b0, exp_done: 3'b100};

    a_port[0] = 22'h3FFFFF; a_port[1] = 22'h000010; a_port[2] = 22'h2AAAAA;
    d_port[0] = 32'hCAFEF00D; d_port[1] = 32'h11111111; d_port[2] = 32'h22222222;

    // ---- init stall: controller not ready for 50 cycles ----
    ready_en = 1'b0; hang1 = 1'b0; svc_cfg = 2;
    rst = 1'b1; req_we = '0; req_rd = 3'b010;
    tick(3);
    chk_zero_outputs("reset");
    rst = 1'b0;
    rd0 = rd_cnt[0];
    tick(50);
    chk("init_no_rd", 64'(rd_cnt[0] - rd0), 64'd0);
    chk("init_busy", 64'(busy[0]), 64'd0);
    ready_en = 1'b1;
    wait_pulse(0, 20, ok);
    chk("init_rd_seen", 64'(ok), 64'd1);
    chk("init_rd_op", 64'({mem_rd[0], mem_we[0]}), 64'b10);
    chk("init_mem_a", 64'(mem_a[0]), 64'h000010);
    tick(1);
    chk("init_rd_1cyc", 64'(mem_rd[0]), 64'd0);
    wait_done(0, 40, cyc, ok);
    chk("init_done_seen", 64'(ok), 64'd1);
    chk("init_done", 64'(rsp_done[0]), 64'b010);
    chk("init_rdata", 64'(rsp_rdata[0]), 64'(model_rd(22'h000010)));
    req_rd = '0;
    chk("init_rd_total", 64'(rd_cnt[0] - rd0), 64'd1);

    // ---- vector table: single transactions from rr_ptr=0 ----
    do_reset();
    tick(2);
    prev_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      svc_cfg = vecs[i].svc;
      rd0 = rd_cnt[0]; we0 = we_cnt[0]; l0 = long_cnt[0];
      req_rd = vecs[i].rd; req_we = vecs[i].we;
      wait_done(0, 200, cyc, ok);
      chk($sformatf("v%0d_done_seen", i), 64'(ok), 64'd1);
      chk($sformatf("v%0d_latency", i), 64'(cyc), 64'(vecs[i].svc + 3));
      chk($sformatf("v%0d_done", i), 64'(rsp_done[0]), 64'(vecs[i].exp_done));
      chk($sformatf("v%0d_err", i), 64'(rsp_err[0]), 64'd0);
      exp_rdata = vecs[i].exp_we ? prev_rdata : model_rd(a_port[vecs[i].port]);
      chk($sformatf("v%0d_rdata", i), 64'(rsp_rdata[0]), 64'(exp_rdata));
      prev_rdata = exp_rdata;
      req_rd = '0; req_we = '0;
      tick(1);
      chk($sformatf("v%0d_done_1cyc", i), 64'(rsp_done[0]), 64'd0);
      chk($sformatf("v%0d_idle", i), 64'(busy[0]), 64'd0);
      chk($sformatf("v%0d_we_pulses", i), 64'(we_cnt[0] - we0), 64'(vecs[i].exp_we));
      chk($sformatf("v%0d_rd_pulses", i), 64'(rd_cnt[0] - rd0), 64'(!vecs[i].exp_we));
      chk($sformatf("v%0d_long_pulse", i), 64'(long_cnt[0] - l0), 64'd0);
      chk($sformatf("v%0d_mem_a", i), 64'(cap_a[0]), 64'(a_port[vecs[i].port]));
      if (vecs[i].exp_we)
        chk($sformatf("v%0d_mem_d", i), 64'(cap_d[0]), 64'(d_port[vecs[i].port]));
    end

    // ---- all ports reading continuously: order 0,1,2,0,1,2 ----
    do_reset();
    tick(2);
    svc_cfg = 1;
    req_rd = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_done(0, 40, cyc, ok);
      chk($sformatf("rr%0d_done_seen", k), 64'(ok), 64'd1);
      chk($sformatf("rr%0d_grant", k), 64'(rsp_done[0]), 64'(3'b001 << (k % 3)));
      chk($sformatf("rr%0d_rdata", k), 64'(rsp_rdata[0]), 64'(model_rd(a_port[k % 3])));
    end
    req_rd = '0;
    tick(6);

    // ---- watchdog on the TO_CYCLES=16 instance ----
    do_reset();
    tick(2);
    svc_cfg = 3;
    req_rd = 3'b001;
    wait_pulse(1, 20, ok);
    chk("to_rd_seen", 64'(ok), 64'd1);
    hang1 = 1'b1;
    wait_done(1, 60, cyc, ok);
    chk("to_done_seen", 64'(ok), 64'd1);
    chk("to_wait_cycles", 64'(cyc), 64'd17);
    chk("to_done", 64'(rsp_done[1]), 64'b001);
    chk("to_err", 64'(rsp_err[1]), 64'd1);
    chk("to_rdata", 64'(rsp_rdata[1]), 64'hDEADBEEF);
    req_rd = '0;
    tick(1);
    chk("to_err_1cyc", 64'(rsp_err[1]), 64'd0);
    rd0 = rd_cnt[1];
    req_rd = 3'b010;
    tick(30);
    chk("to_stall_no_rd", 64'(rd_cnt[1] - rd0), 64'd0);
    chk("to_stall_idle", 64'(busy[1]), 64'd0);
    hang1 = 1'b0;
    wait_done(1, 40, cyc, ok);
    chk("to_next_seen", 64'(ok), 64'd1);
    chk("to_next_done", 64'(rsp_done[1]), 64'b010);
    chk("to_next_err", 64'(rsp_err[1]), 64'd0);
    chk("to_next_rdata", 64'(rsp_rdata[1]), 64'(model_rd(a_port[1])));
    req_rd = '0;

    // ---- reset while in WAIT ----
    do_reset();
    tick(2);
    svc_cfg = 10;
    req_rd = 3'b010;
    wait_pulse(0, 20, ok);
    chk("rst_rd_seen", 64'(ok), 64'd1);
    tick(3);
    chk("rst_in_wait_busy", 64'(busy[0]), 64'd1);
    rst = 1'b1;
    tick(1);
    chk_zero_outputs("rst_wait");
    rst = 1'b0;
    wait_done(0, 60, cyc, ok);
    chk("rst_post_seen", 64'(ok), 64'd1);
    chk("rst_post_latency", 64'(cyc), 64'd14);
    chk("rst_post_done", 64'(rsp_done[0]), 64'b010);
    chk("rst_post_rdata", 64'(rsp_rdata[0]), 64'(model_rd(a_port[1])));
    req_rd = '0;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
